// File: rtl/canvas_reader.sv
// canvas_reader
// Streams a COLS x ROWS pixel canvas, one pixel per valid/ready handshake,
// in row-major order (y outer, x inner) to the network input buffer.
// While a scan is running, Freeze is held high so the canvas editor stops
// writing. When the last beat is accepted, Done pulses for one cycle and
// Sum holds the total of every accepted pixel.
//
// Ports:
//   Clk       - system clock, all state on the rising edge
//   Reset_n   - asynchronous active-low reset, clears every output
//   canvas    - canvas array, indexed canvas[X][Y]
//   Start     - request a scan (sampled only while idle)
//   Abort     - end an active scan early (no Done pulse)
//   pix_data  - registered pixel for the current beat
//   pix_index - linear index y*COLS+x of the current beat
//   pix_valid - beat valid
//   pix_ready - consumer accepts the beat
//   pix_last  - current beat is the final pixel
//   Freeze    - high whenever the reader is not idle
//   Done      - one-cycle pulse after the final beat is accepted
//   Sum       - sum of accepted pixels in the latest scan
module canvas_reader #(
  parameter int COLS  = 28,
  parameter int ROWS  = 28,
  parameter int PIX_W = 16,
  parameter int SUM_W = 26
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [PIX_W-1:0] canvas [COLS][ROWS],
  input  logic             Start,
  input  logic             Abort,
  output logic [PIX_W-1:0] pix_data,
  output logic [9:0]       pix_index,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_last,
  output logic             Freeze,
  output logic             Done,
  output logic [SUM_W-1:0] Sum
);

  localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [9:0] LAST_IDX = 10'(COLS*ROWS - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic          handshake;
  logic          x_wrap;
  logic          at_end;

  assign handshake = (state == STREAM) && pix_ready;

  // Next raster position. At the very last pixel y is held rather than
  // stepped past the array, so the canvas lookup below never leaves the
  // array even though the load it feeds is suppressed there.
  assign x_wrap = (x == XW'(COLS - 1));
  assign at_end = x_wrap && (y == YW'(ROWS - 1));
  assign x_nxt  = x_wrap ? '0 : x + 1'b1;
  assign y_nxt  = (x_wrap && !at_end) ? y + 1'b1 : y;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort takes priority over a simultaneous final handshake, so an
  // aborted scan never reports Done.
  always_comb begin
    state_nxt = state;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    Freeze    = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) state_nxt = STREAM;
      end
      STREAM: begin
        pix_valid = 1'b1;
        Freeze    = 1'b1;
        pix_last  = (pix_index == LAST_IDX);
        if (Abort) begin
          state_nxt = IDLE;
        end else if (handshake && pix_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        Freeze    = 1'b1;
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: a scan start reloads the first pixel and clears Sum; each
  // accepted beat adds its pixel and preloads the next one so pix_data is
  // always a register output. After the last beat the counters stop, and
  // Sum keeps its value until the next accepted Start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x         <= '0;
      y         <= '0;
      pix_data  <= '0;
      pix_index <= '0;
      Sum       <= '0;
    end else if (state == IDLE && Start) begin
      x         <= '0;
      y         <= '0;
      pix_data  <= canvas[0][0];
      pix_index <= '0;
      Sum       <= '0;
    end else if (handshake) begin
      Sum <= Sum + SUM_W'(pix_data);
      if (!pix_last) begin
        x         <= x_nxt;
        y         <= y_nxt;
        pix_data  <= canvas[x_nxt][y_nxt];
        pix_index <= pix_index + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_canvas_reader.sv
// tb_canvas_reader
// Self-checking bench for canvas_reader. A reference model predicts each
// beat directly from the canvas (beat k = canvas[k%COLS][k/COLS]) and keeps
// a running sum of accepted beats. Scans run with ready tied high, random
// backpressure, abort, mid-scan reset, and Start pulses that must be ignored.
module tb_canvas_reader;

  localparam int COLS = 28;
  localparam int ROWS = 28;
  localparam int NPIX = COLS * ROWS;
  localparam int BUDGET = 6000;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic        pix_ready = 1'b0;
  logic [15:0] canvas [COLS][ROWS];
  logic [15:0] pix_data;
  logic [9:0]  pix_index;
  logic        pix_valid;
  logic        pix_last;
  logic        Freeze;
  logic        Done;
  logic [25:0] Sum;

  int testsRun = 0;
  int testsFailed = 0;
  int endBeats;
  logic [31:0] endSum;

  canvas_reader #(.COLS(COLS), .ROWS(ROWS), .PIX_W(16), .SUM_W(26)) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .canvas(canvas),
    .Start(Start),
    .Abort(Abort),
    .pix_data(pix_data),
    .pix_index(pix_index),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_last(pix_last),
    .Freeze(Freeze),
    .Done(Done),
    .Sum(Sum)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 Clk = ~Clk;

  // Single point of comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference pixel for beat k in row-major order.
  function automatic logic [15:0] pixelAt(input int k);
    return canvas[k % COLS][k / COLS];
  endfunction

  // Canvas contents: 0 = X+100*Y, 1 = all zero, 2 = all 16'hFFFF, 3 = random.
  task automatic fillCanvas(input int mode);
    for (int xi = 0; xi < COLS; xi++) begin
      for (int yi = 0; yi < ROWS; yi++) begin
        case (mode)
          0: canvas[xi][yi] = 16'(xi + 100 * yi);
          1: canvas[xi][yi] = 16'h0000;
          2: canvas[xi][yi] = 16'hFFFF;
          default: canvas[xi][yi] = 16'($urandom);
        endcase
      end
    end
  endtask

  // Checks that every output reads zero / idle.
  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_valid"}, pix_valid, 0);
    checkOutput({tag, "_last"}, pix_last, 0);
    checkOutput({tag, "_freeze"}, Freeze, 0);
    checkOutput({tag, "_done"}, Done, 0);
    checkOutput({tag, "_data"}, pix_data, 0);
    checkOutput({tag, "_index"}, pix_index, 0);
    checkOutput({tag, "_sum"}, Sum, 0);
  endtask

  // Runs one scan from Start. Inputs change and outputs are observed on the
  // falling edge, so every decision applies to the next rising edge.
  //   rmode     : 0 = ready always high, 1 = random backpressure
  //   abortBeat : beat number to abort on (-1 = none)
  //   resetBeat : beat number to pull reset on (-1 = none)
  //   pokeStart : pulse Start during STREAM and during DONE
  //   pattern   : canvas holds the X+100*Y pattern (enables fixed-value checks)
  task automatic applyStimulus(input int rmode, input int abortBeat, input int resetBeat,
                               input bit pokeStart, input bit pattern,
                               output int beats, output logic [31:0] sumSeen);
    int k = 0;
    int cyc = 0;
    logic [31:0] modelSum = 0;
    bit holdV = 0;
    bit fin = 0;
    logic [15:0] hd = '0;
    logic [9:0]  hi = '0;
    logic        hl = 1'b0;

    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    cyc = 1;
    checkOutput("start_sum_clear", Sum, 0);
    checkOutput("start_valid", pix_valid, 1);

    while (!fin && cyc < BUDGET) begin
      Start = 1'b0;
      Abort = 1'b0;
      if (holdV) begin
        checkOutput("stall_valid", pix_valid, 1);
        checkOutput("stall_data", pix_data, hd);
        checkOutput("stall_index", pix_index, hi);
        checkOutput("stall_last", pix_last, hl);
        holdV = 0;
      end
      if (Done) begin
        checkOutput("done_beats", k, NPIX);
        if (rmode == 0) checkOutput("done_cycle", cyc, NPIX + 1);
        checkOutput("done_sum", Sum, modelSum);
        checkOutput("done_freeze", Freeze, 1);
        if (pokeStart) Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        checkOutput("done_width", Done, 0);
        checkOutput("after_done_freeze", Freeze, 0);
        checkOutput("after_done_valid", pix_valid, 0);
        checkOutput("after_done_sum", Sum, modelSum);
        fin = 1;
      end else if (pix_valid) begin
        checkOutput("freeze_high", Freeze, 1);
        checkOutput("beat_data", pix_data, pixelAt(k));
        checkOutput("beat_index", pix_index, k);
        checkOutput("beat_last", pix_last, (k == NPIX - 1));
        if (pattern && k == 29) checkOutput("beat29_value", pix_data, 101);
        if (pattern && k == NPIX - 1) checkOutput("beat783_value", pix_data, 2727);
        if (k == resetBeat) begin
          #2 Reset_n = 1'b0;
          #1 checkIdleZero("async_reset");
          @(negedge Clk);
          Reset_n = 1'b1;
          fin = 1;
        end else begin
          pix_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          if (k == abortBeat) begin
            pix_ready = 1'b1;
            Abort = 1'b1;
          end
          if (pokeStart && cyc == 50) Start = 1'b1;
          if (pix_ready) begin
            modelSum += 32'(pixelAt(k));
            k++;
          end else begin
            holdV = 1;
            hd = pix_data;
            hi = pix_index;
            hl = pix_last;
          end
          if (Abort) begin
            @(negedge Clk);
            Abort = 1'b0;
            checkOutput("abort_valid", pix_valid, 0);
            checkOutput("abort_freeze", Freeze, 0);
            checkOutput("abort_done", Done, 0);
            checkOutput("abort_sum", Sum, modelSum);
            @(negedge Clk);
            checkOutput("abort_no_done", Done, 0);
            fin = 1;
          end
        end
      end else begin
        checkOutput("valid_dropped", pix_valid, 1);
        fin = 1;
      end
      if (!fin) begin
        @(negedge Clk);
        cyc++;
      end
    end
    if (!fin) checkOutput("scan_timeout", cyc, BUDGET - 1);
    pix_ready = 1'b0;
    beats = k;
    sumSeen = 32'(Sum);
  endtask

  // Test sequence: reset, pattern scans with and without backpressure,
  // empty canvas with ignored Starts, abort and restart, saturated canvas,
  // and an asynchronous reset in the middle of a scan.
  initial begin
    fillCanvas(0);
    #12;
    checkIdleZero("reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    checkIdleZero("post_reset");

    applyStimulus(0, -1, -1, 1'b0, 1'b1, endBeats, endSum);
    checkOutput("pattern_sum", endSum, 1068984);

    applyStimulus(1, -1, -1, 1'b0, 1'b1, endBeats, endSum);
    checkOutput("backpressure_sum", endSum, 1068984);

    fillCanvas(1);
    applyStimulus(1, -1, -1, 1'b1, 1'b0, endBeats, endSum);
    checkOutput("empty_sum", endSum, 0);
    repeat (3) @(negedge Clk);
    checkOutput("no_second_scan", pix_valid, 0);
    checkOutput("no_second_freeze", Freeze, 0);

    fillCanvas(3);
    applyStimulus(0, 100, -1, 1'b0, 1'b0, endBeats, endSum);
    checkOutput("abort_beats", endBeats, 101);

    applyStimulus(1, -1, -1, 1'b0, 1'b0, endBeats, endSum);
    checkOutput("restart_beats", endBeats, NPIX);

    fillCanvas(2);
    applyStimulus(0, -1, -1, 1'b0, 1'b0, endBeats, endSum);
    checkOutput("saturated_sum", endSum, 51379440);

    fillCanvas(0);
    applyStimulus(0, -1, 300, 1'b0, 1'b0, endBeats, endSum);
    repeat (3) @(negedge Clk);
    checkOutput("reset_release_valid", pix_valid, 0);
    checkOutput("reset_release_freeze", Freeze, 0);
    checkOutput("reset_release_done", Done, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
